// File: rtl/mag_cmp_pkg.sv
// Shared constants for the pipelined magnitude comparator: one-hot result
// encoding {gt, eq, lt}, stats counter width and pipeline depth helper.
package mag_cmp_pkg;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  localparam int STATS_W = 16;

  function automatic int calcStages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/mag_cmp_stage.sv
// One comparator pipeline stage: resolves the top CHUNK bits of the remaining
// operands and registers the result behind a valid/ready slice.
module mag_cmp_stage
  import mag_cmp_pkg::*;
#(
  parameter int PW    = 8,
  parameter int CHUNK = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             decided_i,
  input  logic             gt_i,
  input  logic [PW-1:0]    a_i,
  input  logic [PW-1:0]    b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             decided_o,
  output logic             gt_o,
  output logic [PW-1:0]    a_o,
  output logic [PW-1:0]    b_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [CHUNK-1:0] chunkA, chunkB;
  logic             decided_d, gt_d;
  logic             valid_q, decided_q, gt_q;
  logic [PW-1:0]    a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  assign chunkA = a_i[PW-1 -: CHUNK];
  assign chunkB = b_i[PW-1 -: CHUNK];

  // The first differing chunk, scanning from the MSB, fixes the outcome.
  always_comb begin
    decided_d = decided_i;
    gt_d      = gt_i;
    if (!decided_i && (chunkA != chunkB)) begin
      decided_d = 1'b1;
      gt_d      = (chunkA > chunkB);
    end
  end

  assign ready_o = ~valid_q | ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        decided_q <= decided_d;
        gt_q      <= gt_d;
        a_q       <= a_i << CHUNK;
        b_q       <= b_i << CHUNK;
        tag_q     <= tag_i;
      end
    end
  end

  assign valid_o   = valid_q;
  assign decided_o = decided_q;
  assign gt_o      = gt_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign tag_o     = tag_q;

endmodule

// File: rtl/magnitude_comparator_pipe.sv
// Pipelined MSB-first magnitude comparator, CHUNK bits per stage, with
// valid/ready on both sides. Define MAG_CMP_STATS_EN for result counters.
module magnitude_comparator_pipe
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               AgtB,
  output logic               AeqB,
  output logic               AltB,
`ifdef MAG_CMP_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] gt_cnt,
  output logic [STATS_W-1:0] eq_cnt,
  output logic [STATS_W-1:0] lt_cnt,
`endif
  output logic [TAG_W-1:0]   out_tag
);

  localparam int STAGES = calcStages(WIDTH, CHUNK);
  localparam int PW     = STAGES * CHUNK;

  logic [WIDTH-1:0] signMask, aEntry, bEntry;
  logic [PW-1:0]    aPad, bPad;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign signMask = {signed_mode, {(WIDTH-1){1'b0}}};
  assign aEntry   = A ^ signMask;
  assign bEntry   = B ^ signMask;
  assign aPad     = PW'(aEntry) << (PW - WIDTH);
  assign bPad     = PW'(bEntry) << (PW - WIDTH);

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic             vIn, rIn, dIn, gIn, vOut, rOut, dOut, gOut;
    logic [PW-1:0]    aIn, bIn, aOut, bOut;
    logic [TAG_W-1:0] tIn, tOut;

    if (k == 0) begin : head
      assign vIn      = in_valid;
      assign dIn      = 1'b0;
      assign gIn      = 1'b0;
      assign aIn      = aPad;
      assign bIn      = bPad;
      assign tIn      = in_tag;
      assign in_ready = rIn;
    end else begin : link
      assign vIn = stg[k-1].vOut;
      assign dIn = stg[k-1].dOut;
      assign gIn = stg[k-1].gOut;
      assign aIn = stg[k-1].aOut;
      assign bIn = stg[k-1].bOut;
      assign tIn = stg[k-1].tOut;
    end

    if (k == STAGES - 1) begin : tail
      assign rOut = out_ready;
    end else begin : mid
      assign rOut = stg[k+1].rIn;
    end

    mag_cmp_stage #(.PW(PW), .CHUNK(CHUNK), .TAG_W(TAG_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (vIn),
      .ready_o  (rIn),
      .decided_i(dIn),
      .gt_i     (gIn),
      .a_i      (aIn),
      .b_i      (bIn),
      .tag_i    (tIn),
      .valid_o  (vOut),
      .ready_i  (rOut),
      .decided_o(dOut),
      .gt_o     (gOut),
      .a_o      (aOut),
      .b_o      (bOut),
      .tag_o    (tOut)
    );
  end

  logic       unusedOps;
  logic [2:0] resFlags;

  assign unusedOps = ^{stg[STAGES-1].aOut, stg[STAGES-1].bOut};
  assign out_valid = stg[STAGES-1].vOut;
  assign out_tag   = stg[STAGES-1].tOut;

  always_comb begin
    resFlags = '0;
    if (out_valid) begin
      if (!stg[STAGES-1].dOut)     resFlags = RES_EQ;
      else if (stg[STAGES-1].gOut) resFlags = RES_GT;
      else                         resFlags = RES_LT;
    end
  end

  assign {AgtB, AeqB, AltB} = resFlags;

`ifdef MAG_CMP_STATS_EN
  logic [STATS_W-1:0] gtCnt_q, eqCnt_q, ltCnt_q;
  logic               outFire;

  assign outFire = out_valid & out_ready;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gtCnt_q <= '0;
      eqCnt_q <= '0;
      ltCnt_q <= '0;
    end else if (stats_clr) begin
      gtCnt_q <= '0;
      eqCnt_q <= '0;
      ltCnt_q <= '0;
    end else if (outFire) begin
      if (AgtB && (gtCnt_q != '1)) gtCnt_q <= gtCnt_q + 1'b1;
      if (AeqB && (eqCnt_q != '1)) eqCnt_q <= eqCnt_q + 1'b1;
      if (AltB && (ltCnt_q != '1)) ltCnt_q <= ltCnt_q + 1'b1;
    end
  end

  assign gt_cnt = gtCnt_q;
  assign eq_cnt = eqCnt_q;
  assign lt_cnt = ltCnt_q;
`endif

endmodule
